bitmap_index_serializer: RTL and testbench

//  Sequential successor to the one-hot encoder: accepts a multi-hot bitmap and emits the index of

---
 rtl/enc_pkg.sv | 12 +
 rtl/lsb_priority_encoder.sv | 24 ++
 rtl/bitmap_index_serializer.sv | 115 +++++++++++
 tb/tb_bitmap_index_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types for the bitmap index serializer: FSM state encoding and selection-mode constants.
package enc_pkg;

    typedef enum logic {
        IDLE,
        DRAIN
    } bis_state_e;

    localparam int BIS_MODE_FIXED = 0;
    localparam int BIS_MODE_RR    = 1;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational priority encoder: reports the index of the lowest set bit of mask_i and whether any bit is set.
module lsb_priority_encoder #(
    parameter int NUM_WIRE = 16
) (
    input  logic [NUM_WIRE-1:0]         mask_i,
    output logic [$clog2(NUM_WIRE)-1:0] index_o,
    output logic                        found_o
);

    localparam int IW = $clog2(NUM_WIRE);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index_o = '0;
        found_o = 1'b0;
        for (int i = NUM_WIRE - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                index_o = IW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitmap_index_serializer.sv
// Accepts a multi-hot bitmap and emits the index of each set bit, one per valid/ready handshake,
// lowest-first (MODE 0) or round-robin from the last emitted index + 1 (MODE 1).
module bitmap_index_serializer
    import enc_pkg::*;
#(
    parameter int NUM_WIRE = 16,
    parameter int MODE     = BIS_MODE_FIXED
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_WIRE-1:0]         wire_in,
    input  logic                        wire_valid_i,
    output logic                        wire_ready_o,
    output logic [$clog2(NUM_WIRE)-1:0] index_o,
    output logic                        index_valid_o,
    input  logic                        index_ready_i,
    output logic                        last_o,
    output logic [$clog2(NUM_WIRE):0]   count_o
);

    localparam int IW = $clog2(NUM_WIRE);
    localparam logic [IW:0]         NW  = (IW + 1)'(NUM_WIRE);
    localparam logic [NUM_WIRE-1:0] ONE = NUM_WIRE'(1);

    // Valid/ready: a transfer happens on any rising edge where both valid and ready are high;
    // a raised valid is never withdrawn and its payload never changes until that transfer.

    bis_state_e          state_q, state_d;
    logic [NUM_WIRE-1:0] mask_q, mask_d;
    logic [IW-1:0]       ptr_q, ptr_d;

    logic [NUM_WIRE-1:0] rot_mask, enc_mask;
    logic [IW-1:0]       enc_idx, sel_idx;
    logic                enc_found;
    logic [IW:0]         idx_sum, idx_inc, pop_cnt;
    logic                drain, idx_fire, load_fire;

    function automatic logic [IW:0] popcount(input logic [NUM_WIRE-1:0] v);
        logic [IW:0] c;
        c = '0;
        for (int i = 0; i < NUM_WIRE; i++) begin
            c = c + (IW + 1)'(v[i]);
        end
        return c;
    endfunction

    // Round-robin: rotate so that bit ptr lands at position 0, encode, then undo the rotation.
    always_comb begin
        rot_mask = NUM_WIRE'({mask_q, mask_q} >> ptr_q);
        enc_mask = (MODE == BIS_MODE_RR) ? rot_mask : mask_q;
    end

    lsb_priority_encoder #(
        .NUM_WIRE(NUM_WIRE)
    ) u_lsb_enc (
        .mask_i (enc_mask),
        .index_o(enc_idx),
        .found_o(enc_found)
    );

    always_comb begin
        idx_sum = {1'b0, enc_idx} + {1'b0, ptr_q};
        if (MODE == BIS_MODE_RR) begin
            sel_idx = (idx_sum >= NW) ? IW'(idx_sum - NW) : idx_sum[IW-1:0];
        end else begin
            sel_idx = enc_idx;
        end
        pop_cnt = popcount(mask_q);
    end

    always_comb begin
        drain         = (state_q == DRAIN);
        index_valid_o = drain && enc_found;
        index_o       = drain ? sel_idx : '0;
        count_o       = pop_cnt;
        last_o        = drain && (pop_cnt == (IW + 1)'(1));
        idx_fire      = index_valid_o && index_ready_i;
        wire_ready_o  = !drain || (index_valid_o && last_o && index_ready_i);
        load_fire     = wire_valid_i && wire_ready_o;
        idx_inc       = {1'b0, index_o} + (IW + 1)'(1);
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        if (idx_fire) begin
            mask_d = mask_q & ~(ONE << index_o);
            if (MODE == BIS_MODE_RR) begin
                ptr_d = (idx_inc == NW) ? '0 : idx_inc[IW-1:0];
            end
            if (last_o) begin
                state_d = IDLE;
            end
        end
        // A load in the same cycle as the final index handshake overrides the clear above.
        if (load_fire) begin
            mask_d  = wire_in;
            state_d = (wire_in != '0) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_bitmap_index_serializer.sv
// Directed bench: fixed-priority 16-wide, round-robin 16-wide and round-robin 12-wide instances.
module tb_bitmap_index_serializer;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    logic [15:0] a_win;
    logic        a_wv, a_wr, a_iv, a_ir, a_last;
    logic [3:0]  a_idx;
    logic [4:0]  a_cnt;

    logic [15:0] b_win;
    logic        b_wv, b_wr, b_iv, b_ir, b_last;
    logic [3:0]  b_idx;
    logic [4:0]  b_cnt;

    logic [11:0] c_win;
    logic        c_wv, c_wr, c_iv, c_ir, c_last;
    logic [3:0]  c_idx;
    logic [4:0]  c_cnt;

    bitmap_index_serializer #(.NUM_WIRE(16), .MODE(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .wire_in(a_win), .wire_valid_i(a_wv), .wire_ready_o(a_wr),
        .index_o(a_idx), .index_valid_o(a_iv), .index_ready_i(a_ir), .last_o(a_last), .count_o(a_cnt)
    );

    bitmap_index_serializer #(.NUM_WIRE(16), .MODE(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .wire_in(b_win), .wire_valid_i(b_wv), .wire_ready_o(b_wr),
        .index_o(b_idx), .index_valid_o(b_iv), .index_ready_i(b_ir), .last_o(b_last), .count_o(b_cnt)
    );

    bitmap_index_serializer #(.NUM_WIRE(12), .MODE(1)) dut_c (
        .clk_i(clk), .rst_i(rst), .wire_in(c_win), .wire_valid_i(c_wv), .wire_ready_o(c_wr),
        .index_o(c_idx), .index_valid_o(c_iv), .index_ready_i(c_ir), .last_o(c_last), .count_o(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [11:0] want;
        @(negedge clk);
        rst = 1'b1;
        a_wv = 1'b1; a_win = 16'hFFFF;
        b_wv = 1'b1; b_win = 16'hFFFF;
        c_wv = 1'b1; c_win = 12'hFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        want = {1'b1, 1'b0, 4'd0, 1'b0, 5'd0};
        tests_run++;
        if ({a_wr, a_iv, a_idx, a_last, a_cnt} !== want) begin
            tests_failed++;
            $display("FAIL reset_a: got %b want %b", {a_wr, a_iv, a_idx, a_last, a_cnt}, want);
        end
        tests_run++;
        if ({b_wr, b_iv, b_idx, b_last, b_cnt} !== want) begin
            tests_failed++;
            $display("FAIL reset_b: got %b want %b", {b_wr, b_iv, b_idx, b_last, b_cnt}, want);
        end
        tests_run++;
        if ({c_wr, c_iv, c_idx, c_last, c_cnt} !== want) begin
            tests_failed++;
            $display("FAIL reset_c: got %b want %b", {c_wr, c_iv, c_idx, c_last, c_cnt}, want);
        end
        @(negedge clk);
        rst = 1'b0;
        a_wv = 1'b0; b_wv = 1'b0; c_wv = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({a_iv, b_iv, c_iv} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_noload: got valids %b want 000", {a_iv, b_iv, c_iv});
        end
    endtask

    task automatic test_mode0_drain();
        int exp_idx[4] = '{0, 5, 10, 15};
        @(negedge clk);
        a_ir = 1'b1; a_win = 16'h8421; a_wv = 1'b1;
        @(negedge clk);
        a_wv = 1'b0; a_win = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if ({a_iv, a_idx, a_last, a_cnt} !== {1'b1, 4'(exp_idx[i]), (i == 3), 5'(4 - i)}) begin
                tests_failed++;
                $display("FAIL m0_drain[%0d]: got v=%b idx=%0d last=%b cnt=%0d want idx=%0d last=%b cnt=%0d",
                         i, a_iv, a_idx, a_last, a_cnt, exp_idx[i], (i == 3), 4 - i);
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if ({a_iv, a_wr} !== 2'b01) begin
            tests_failed++;
            $display("FAIL m0_done: got v=%b rdy=%b want v=0 rdy=1", a_iv, a_wr);
        end
    endtask

    task automatic test_rr_wrap();
        int exp_idx[3] = '{6, 0, 5};
        @(negedge clk);
        b_ir = 1'b1; b_win = 16'h0020; b_wv = 1'b1;
        @(negedge clk);
        b_wv = 1'b0;
        #1;
        tests_run++;
        if ({b_iv, b_idx, b_last, b_cnt} !== {1'b1, 4'd5, 1'b1, 5'd1}) begin
            tests_failed++;
            $display("FAIL rr_prime: got v=%b idx=%0d last=%b cnt=%0d want v=1 idx=5 last=1 cnt=1",
                     b_iv, b_idx, b_last, b_cnt);
        end
        @(negedge clk);
        b_win = 16'h0061; b_wv = 1'b1;
        @(negedge clk);
        b_wv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if ({b_iv, b_idx, b_last, b_cnt} !== {1'b1, 4'(exp_idx[i]), (i == 2), 5'(3 - i)}) begin
                tests_failed++;
                $display("FAIL rr_wrap[%0d]: got v=%b idx=%0d last=%b cnt=%0d want idx=%0d last=%b cnt=%0d",
                         i, b_iv, b_idx, b_last, b_cnt, exp_idx[i], (i == 2), 3 - i);
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (b_iv !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_done: got v=%b want 0", b_iv);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        a_ir = 1'b1; a_win = 16'h0021; a_wv = 1'b1;
        @(negedge clk);
        a_wv = 1'b0;
        #1;
        tests_run++;
        if ({a_iv, a_idx, a_cnt} !== {1'b1, 4'd0, 5'd2}) begin
            tests_failed++;
            $display("FAIL bp_first: got v=%b idx=%0d cnt=%0d want v=1 idx=0 cnt=2", a_iv, a_idx, a_cnt);
        end
        @(negedge clk);
        a_ir = 1'b0; a_win = 16'hFFFF; a_wv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if ({a_wr, a_iv, a_idx, a_last, a_cnt} !== {1'b0, 1'b1, 4'd5, 1'b1, 5'd1}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b idx=%0d last=%b cnt=%0d want rdy=0 v=1 idx=5 last=1 cnt=1",
                         k, a_wr, a_iv, a_idx, a_last, a_cnt);
            end
            @(negedge clk);
        end
        a_wv = 1'b0; a_win = '0; a_ir = 1'b1;
        #1;
        tests_run++;
        if ({a_wr, a_iv, a_idx} !== {1'b1, 1'b1, 4'd5}) begin
            tests_failed++;
            $display("FAIL bp_release: got rdy=%b v=%b idx=%0d want rdy=1 v=1 idx=5", a_wr, a_iv, a_idx);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (a_iv !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_done: got v=%b want 0", a_iv);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a_ir = 1'b1; a_win = 16'h0003; a_wv = 1'b1;
        @(negedge clk);
        a_win = 16'h0100;
        #1;
        tests_run++;
        if ({a_wr, a_iv, a_idx, a_last, a_cnt} !== {1'b0, 1'b1, 4'd0, 1'b0, 5'd2}) begin
            tests_failed++;
            $display("FAIL b2b_0: got rdy=%b v=%b idx=%0d last=%b cnt=%0d want rdy=0 v=1 idx=0 last=0 cnt=2",
                     a_wr, a_iv, a_idx, a_last, a_cnt);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({a_wr, a_iv, a_idx, a_last, a_cnt} !== {1'b1, 1'b1, 4'd1, 1'b1, 5'd1}) begin
            tests_failed++;
            $display("FAIL b2b_1: got rdy=%b v=%b idx=%0d last=%b cnt=%0d want rdy=1 v=1 idx=1 last=1 cnt=1",
                     a_wr, a_iv, a_idx, a_last, a_cnt);
        end
        @(negedge clk);
        a_wv = 1'b0; a_win = '0;
        #1;
        tests_run++;
        if ({a_iv, a_idx, a_last, a_cnt} !== {1'b1, 4'd8, 1'b1, 5'd1}) begin
            tests_failed++;
            $display("FAIL b2b_8: got v=%b idx=%0d last=%b cnt=%0d want v=1 idx=8 last=1 cnt=1",
                     a_iv, a_idx, a_last, a_cnt);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (a_iv !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_done: got v=%b want 0", a_iv);
        end
    endtask

    task automatic test_zero_bitmap();
        @(negedge clk);
        a_win = '0; a_wv = 1'b1;
        #1;
        tests_run++;
        if (a_wr !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_accept: got rdy=%b want 1", a_wr);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a_wv = 1'b0;
            #1;
            tests_run++;
            if ({a_wr, a_iv, a_cnt} !== {1'b1, 1'b0, 5'd0}) begin
                tests_failed++;
                $display("FAIL zero_drop[%0d]: got rdy=%b v=%b cnt=%0d want rdy=1 v=0 cnt=0",
                         k, a_wr, a_iv, a_cnt);
            end
        end
    endtask

    task automatic test_n12_rr_reset();
        @(negedge clk);
        c_ir = 1'b1; c_win = 12'hFFF; c_wv = 1'b1;
        @(negedge clk);
        c_wv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            tests_run++;
            if ({c_iv, c_idx, c_last, c_cnt} !== {1'b1, 4'(i), (i == 11), 5'(12 - i)}) begin
                tests_failed++;
                $display("FAIL n12_drain[%0d]: got v=%b idx=%0d last=%b cnt=%0d want idx=%0d last=%b cnt=%0d",
                         i, c_iv, c_idx, c_last, c_cnt, i, (i == 11), 12 - i);
            end
            @(negedge clk);
        end
        c_wv = 1'b1;
        @(negedge clk);
        c_wv = 1'b0;
        #1;
        tests_run++;
        if ({c_iv, c_idx, c_cnt} !== {1'b1, 4'd0, 5'd12}) begin
            tests_failed++;
            $display("FAIL n12_ptr_wrap: got v=%b idx=%0d cnt=%0d want v=1 idx=0 cnt=12", c_iv, c_idx, c_cnt);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({c_idx, c_cnt} !== {4'd1, 5'd11}) begin
            tests_failed++;
            $display("FAIL n12_second: got idx=%0d cnt=%0d want idx=1 cnt=11", c_idx, c_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if ({c_wr, c_iv, c_idx, c_last, c_cnt} !== {1'b1, 1'b0, 4'd0, 1'b0, 5'd0}) begin
            tests_failed++;
            $display("FAIL n12_mid_reset: got rdy=%b v=%b idx=%0d last=%b cnt=%0d want rdy=1 v=0 idx=0 last=0 cnt=0",
                     c_wr, c_iv, c_idx, c_last, c_cnt);
        end
        c_win = 12'h801; c_wv = 1'b1;
        @(negedge clk);
        c_wv = 1'b0;
        #1;
        tests_run++;
        if ({c_iv, c_idx, c_last, c_cnt} !== {1'b1, 4'd0, 1'b0, 5'd2}) begin
            tests_failed++;
            $display("FAIL n12_ptr_cleared: got v=%b idx=%0d last=%b cnt=%0d want v=1 idx=0 last=0 cnt=2",
                     c_iv, c_idx, c_last, c_cnt);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if ({c_iv, c_idx, c_last} !== {1'b1, 4'd11, 1'b1}) begin
            tests_failed++;
            $display("FAIL n12_after_reset: got v=%b idx=%0d last=%b want v=1 idx=11 last=1", c_iv, c_idx, c_last);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        a_win = '0; a_wv = 1'b0; a_ir = 1'b0;
        b_win = '0; b_wv = 1'b0; b_ir = 1'b0;
        c_win = '0; c_wv = 1'b0; c_ir = 1'b0;
        test_reset();
        test_mode0_drain();
        test_rr_wrap();
        test_backpressure();
        test_back_to_back();
        test_zero_bitmap();
        test_n12_rr_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
